// File: rtl/seq_detect_sched.sv
// Round-robin shared pattern matcher: one serial bit per cycle is taken from the
// next requesting channel and matched against a configurable pattern using per-channel history.
module seq_detect_sched #(
   parameter int              NCH     = 4,
   parameter int              PLEN    = 4,
   parameter int              CNTW    = 8,
   parameter logic [PLEN-1:0] RST_PAT = 4'b1011
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     cfg_we,
   input  logic [PLEN-1:0]          cfg_pattern,
   input  logic                     cfg_overlap,
   input  logic [NCH-1:0]           req_valid,
   input  logic [NCH-1:0]           req_bit,
   output logic [NCH-1:0]           req_ready,
   output logic                     hit_valid,
   output logic [$clog2(NCH)-1:0]   hit_ch,
   output logic [CNTW-1:0]          hit_count,
   output logic                     busy
);

   // state | meaning
   // IDLE  | no grants; config writes accepted (they clear contexts and hit_count)
   // RUN   | one channel granted per cycle in round-robin order; config ignored
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam int CHW = $clog2(NCH);
   localparam int FW  = $clog2(PLEN + 1);

   state_t          state;
   logic [PLEN-1:0] pattern;
   logic            overlap;
   logic [CHW-1:0]  rr_ptr;
   logic [PLEN-1:0] hist [NCH];
   logic [FW-1:0]   fill [NCH];

   logic            gnt_any;
   logic [CHW-1:0]  gnt_idx;
   logic [CHW-1:0]  scan_idx;
   logic [PLEN-1:0] cur_hist;
   logic [FW-1:0]   cur_fill;
   logic [PLEN-1:0] nh;
   logic [FW-1:0]   nf;
   logic            match;
   logic [CHW-1:0]  rr_next;

   assign busy = (state == S_RUN);

   // Dropping enable suppresses the grant in the same cycle, not just the next one.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      if (state == S_RUN && enable) begin
         for (int k = 0; k < NCH; k++) begin
            scan_idx = CHW'((int'(rr_ptr) + k) % NCH);
            if (!gnt_any && req_valid[scan_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = scan_idx;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      cur_hist = hist[gnt_idx];
      cur_fill = fill[gnt_idx];
      nh       = {cur_hist[PLEN-2:0], req_bit[gnt_idx]};
      nf       = (cur_fill == FW'(PLEN)) ? FW'(PLEN) : cur_fill + FW'(1);
      match    = gnt_any && (nf == FW'(PLEN)) && (nh == pattern);
      rr_next  = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         pattern   <= RST_PAT;
         overlap   <= 1'b0;
         rr_ptr    <= '0;
         hit_valid <= 1'b0;
         hit_ch    <= '0;
         hit_count <= '0;
         for (int c = 0; c < NCH; c++) begin
            hist[c] <= '0;
            fill[c] <= '0;
         end
      end else begin
         hit_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_we) begin
                  pattern   <= cfg_pattern;
                  overlap   <= cfg_overlap;
                  hit_count <= '0;
                  for (int c = 0; c < NCH; c++) begin
                     hist[c] <= '0;
                     fill[c] <= '0;
                  end
               end else if (enable) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else if (gnt_any) begin
                  rr_ptr <= rr_next;
                  if (match && !overlap) begin
                     hist[gnt_idx] <= '0;
                     fill[gnt_idx] <= '0;
                  end else begin
                     hist[gnt_idx] <= nh;
                     fill[gnt_idx] <= nf;
                  end
                  if (match) begin
                     hit_valid <= 1'b1;
                     hit_ch    <= gnt_idx;
                     if (hit_count != {CNTW{1'b1}}) hit_count <= hit_count + CNTW'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: expected hits are queued at stimulus time and
// a negedge monitor pops them whenever hit_valid is seen, checking channel and latency.
module tb_seq_detect_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_pattern = 4'b0000;
   logic       cfg_overlap = 1'b0;
   logic [3:0] req_valid = 4'b0000;
   logic [3:0] req_bit = 4'b0000;
   logic [3:0] req_ready;
   logic       hit_valid;
   logic [1:0] hit_ch;
   logic [7:0] hit_count;
   logic       busy;

   logic [3:0] sat_ready;
   logic       sat_hv;
   logic [1:0] sat_ch;
   logic [1:0] sat_count;
   logic       sat_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_cnt = 0;
   int exp_ch_q[$];
   int exp_cyc_q[$];

   seq_detect_sched #(.NCH(4), .PLEN(4), .CNTW(8), .RST_PAT(4'b1011)) dut (
      .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
      .req_valid(req_valid), .req_bit(req_bit), .req_ready(req_ready),
      .hit_valid(hit_valid), .hit_ch(hit_ch), .hit_count(hit_count), .busy(busy)
   );

   // Same stimulus, narrow counter: only its saturating hit_count is examined.
   seq_detect_sched #(.NCH(4), .PLEN(4), .CNTW(2), .RST_PAT(4'b1011)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
      .req_valid(req_valid), .req_bit(req_bit), .req_ready(sat_ready),
      .hit_valid(sat_hv), .hit_ch(sat_ch), .hit_count(sat_count), .busy(sat_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every hit pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (hit_valid) begin
         if (exp_ch_q.size() == 0) begin
            chk("unexpected_hit_ch", int'(hit_ch), -1);
         end else begin
            chk("hit_ch", int'(hit_ch), exp_ch_q.pop_front());
            chk("hit_latency_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
   end

   task automatic expect_hit(input int ch);
      exp_ch_q.push_back(ch);
      exp_cyc_q.push_back(cyc + 1);
      exp_cnt++;
   endtask

   task automatic send(input int ch, input bit b, input bit exp_hit);
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 4'b0000;
      req_valid[ch] = 1'b1;
      req_bit[ch] = b;
      #1;
      while (!req_ready[ch] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready[ch]) chk("grant_timeout", 0, 1);
      else if (exp_hit) expect_hit(ch);
      @(posedge clk);
   endtask

   task automatic send4(input int ch, input logic [3:0] bits, input logic [3:0] hits);
      for (int i = 3; i >= 0; i--) send(ch, bits[i], hits[i]);
   endtask

   task automatic settle_and_check(input string tag);
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (3) @(negedge clk);
      chk({tag, "_pending_hits"}, exp_ch_q.size(), 0);
      chk({tag, "_hit_count"}, int'(hit_count), exp_cnt);
      chk({tag, "_sat_count"}, int'(sat_count), (exp_cnt > 3) ? 3 : exp_cnt);
   endtask

   task automatic go_idle_and_cfg(input logic [3:0] pat, input bit ovl);
      int n;
      n = 0;
      @(negedge clk);
      enable = 1'b0;
      req_valid = 4'b0000;
      while (busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("busy_drop", int'(busy), 0);
      cfg_we = 1'b1;
      cfg_pattern = pat;
      cfg_overlap = ovl;
      @(negedge clk);
      cfg_we = 1'b0;
      exp_cnt = 0;
      #1;
      chk("cfg_clear_count", int'(hit_count), 0);
      chk("cfg_stays_idle", int'(busy), 0);
      enable = 1'b1;
   endtask

   initial begin
      logic [3:0] p1011;
      p1011 = 4'b1011;

      // Reset state with requests pending in IDLE
      req_valid = 4'b1111;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_hit_valid", int'(hit_valid), 0);
      chk("rst_hit_ch", int'(hit_ch), 0);
      chk("rst_hit_count", int'(hit_count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("idle_req_ready", int'(req_ready), 0);
      req_valid = 4'b0000;
      enable = 1'b1;
      @(negedge clk);
      chk("run_busy", int'(busy), 1);

      // Fairness: all valid, one 1011 bit per round, grants 0,1,2,3 repeating
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         req_valid = 4'b1111;
         req_bit = {4{p1011[3 - k / 4]}};
         #1;
         chk("rr_grant", int'(req_ready), 1 << (k % 4));
         if (k >= 12) expect_hit(k % 4);
         @(posedge clk);
      end
      settle_and_check("fair");

      // Config write while busy is ignored: 1011 still detected on ch1
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_pattern = 4'b0110;
      cfg_overlap = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      chk("busy_cfg_keeps_count", int'(hit_count), 4);
      send4(1, 4'b1011, 4'b0001);
      settle_and_check("cfg_ignored");

      // Single channel, no overlap: 1,0,1,1,0,1,1 -> one hit
      go_idle_and_cfg(4'b1011, 1'b0);
      send4(0, 4'b1011, 4'b0001);
      send(0, 1'b0, 1'b0);
      send(0, 1'b1, 1'b0);
      send(0, 1'b1, 1'b0);
      settle_and_check("single");

      // Context isolation: ch0 holds 0,1,1 then gets 1,0,1; ch2 1011; ch0 1
      send(0, 1'b1, 1'b0);
      send(0, 1'b0, 1'b0);
      send(0, 1'b1, 1'b0);
      send4(2, 4'b1011, 4'b0001);
      send(0, 1'b1, 1'b1);
      settle_and_check("isolation");

      // Overlap on: 1,0,1,0,1,0 on ch1 -> hits after accepts 4 and 6
      go_idle_and_cfg(4'b1010, 1'b1);
      send4(1, 4'b1010, 4'b0001);
      send(1, 1'b1, 1'b0);
      send(1, 1'b0, 1'b1);
      settle_and_check("overlap_on");

      // Overlap off: same stream -> one hit
      go_idle_and_cfg(4'b1010, 1'b0);
      send4(1, 4'b1010, 4'b0001);
      send(1, 1'b1, 1'b0);
      send(1, 1'b0, 1'b0);
      settle_and_check("overlap_off");

      // New pattern written in IDLE, detected on ch3
      go_idle_and_cfg(4'b0110, 1'b0);
      send4(3, 4'b0110, 4'b0001);
      settle_and_check("cfg_idle");

      // Five more matches: narrow counter saturates at 3
      for (int i = 0; i < 5; i++) send4(0, 4'b0110, 4'b0001);
      settle_and_check("saturate");

      // Mid-run reset on the edge accepting a would-be match bit
      send(1, 1'b0, 1'b0);
      send(1, 1'b1, 1'b0);
      send(1, 1'b1, 1'b0);
      @(negedge clk);
      req_valid = 4'b0010;
      req_bit[1] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req_valid = 4'b1111;
      exp_cnt = 0;
      #1;
      chk("midrst_hit_valid", int'(hit_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_count", int'(hit_count), 0);
      chk("midrst_sat_count", int'(sat_count), 0);
      chk("midrst_req_ready", int'(req_ready), 0);
      @(negedge clk);
      req_valid = 4'b0000;
      chk("midrst_no_late_hit", int'(hit_valid), 0);

      // Pattern back to 1011: 0110 no longer matches, 1011 does
      send4(0, 4'b0110, 4'b0000);
      send4(1, 4'b1011, 4'b0001);
      settle_and_check("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
